drive_sequencer: RTL and testbench
==================================

DRIVE_SEQUENCER -- requirements
Module: drive_sequencer

Interface
REQ-001 Parameter CRUISE_US, default 2000000, cruise duration in clk_1mhz cycles.
REQ-002 Parameter WDOG_US, default 1200000, maximum ACCEL or DECEL phase length in cycles.
REQ-003 Parameter CNT_W, default 22, width of the phase counter; SHALL satisfy 2^CNT_W > max(CRUISE_US, WDOG_US).
REQ-004 clk_1mhz  in  1  1 MHz system clock; all logic on its rising edge.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 go  in  1  run request; a rising edge starts a run.
REQ-007 stop_req  in  1  level; requests early deceleration.
REQ-008 estop  in  1  level; emergency stop, highest priority.
REQ-009 fault_clr  in  1  level; clears FAULT.
REQ-010 accelerated / accel_pwm  in  1 each  accelerator done flag / accelerator PWM.
REQ-011 decelerated / decel_pwm  in  1 each  decelerator done flag / decelerator PWM.
REQ-012 accel_start / decel_start  out  1 each  one-cycle start pulses to the accelerator / decelerator.
REQ-013 pwm_out  out  1  registered motor PWM.
REQ-014 busy / done / fault  out  1 each  status flags.
REQ-015 fault_cause  out  2  01 = estop, 10 = watchdog, 00 = none.
REQ-016 state  out  3  IDLE=0, ACCEL=1, CRUISE=2, DECEL=3, DONE=4, FAULT=5.

Function
REQ-017 IDLE: a go rising edge SHALL enter ACCEL and assert accel_start for exactly one cycle.
REQ-018 ACCEL: a rising edge on accelerated SHALL enter CRUISE with the counter cleared; if stop_req was seen high at any point during ACCEL (latched), it SHALL instead enter DECEL and pulse decel_start.
REQ-019 CRUISE: when the counter reaches CRUISE_US-1, or when stop_req is high, the block SHALL enter DECEL and pulse decel_start exactly once, including when both occur in the same cycle.
REQ-020 DECEL: a rising edge on decelerated SHALL enter DONE; only rising edges count, because decelerated is high from the previous run.
REQ-021 DONE: done=1; the block SHALL return to IDLE in the first cycle in which go=0.
REQ-022 estop=1 in any state other than IDLE SHALL enter FAULT on the next edge with fault_cause=01, overriding every other transition.
REQ-023 FAULT: fault=1 and pwm_out=0; the block SHALL return to IDLE only when fault_clr=1 and estop=0, and fault_cause SHALL then clear to 00.
REQ-024 pwm_out SHALL be registered, one cycle behind its source: IDLE 0, ACCEL accel_pwm, CRUISE 1, DECEL decel_pwm, DONE 0, FAULT 0.
REQ-025 busy SHALL equal 1 in ACCEL, CRUISE and DECEL, and 0 in all other states.
REQ-026 The phase counter SHALL clear on every state entry and increment once per cycle, saturating at all-ones with no wrap-around.
REQ-027 A completion edge (accelerated or decelerated) occurring in the same cycle as watchdog expiry SHALL take precedence over the watchdog.
REQ-028 The go edge detector SHALL ignore go edges outside IDLE.

Reset
REQ-029 While reset_n=0, state=IDLE and accel_start, decel_start, pwm_out, busy, done, fault, fault_cause and the counter SHALL all be 0, asynchronously.
REQ-030 After reset, go_prev SHALL be 1, so a go held high through reset release does not start a run; accelerated_prev, decelerated_prev and the stop latch SHALL be 0.
REQ-031 Reset asserted mid-run SHALL abort the run immediately, with no start pulse emitted.

Configuration
REQ-032 With SEQ_WATCHDOG_EN defined, ACCEL or DECEL lasting WDOG_US cycles without completion SHALL enter FAULT with fault_cause=01 replaced by 10, that is, fault_cause=10.
REQ-033 Without SEQ_WATCHDOG_EN, no watchdog logic SHALL exist, FAULT SHALL be reachable only via estop, and the port list SHALL be unchanged (fault_cause is never 10).

Verification (CRUISE_US=50, WDOG_US=200)
REQ-034 go rising, accelerated rising 100 cycles later, decelerated rising 100 cycles after decel_start -> states 1,2,3,4; one pulse on each start output; CRUISE lasts exactly 50 cycles; pwm_out=1 throughout CRUISE.
REQ-035 stop_req=1 at cycle 10 of CRUISE -> DECEL on the next edge, one decel_start pulse, and cruise does not complete.
REQ-036 estop=1 during DECEL -> state=5, fault_cause=01, pwm_out=0 after 1 cycle; fault_clr with estop=1 -> stays in FAULT; fault_clr with estop=0 -> IDLE.
REQ-037 SEQ_WATCHDOG_EN defined, accelerated never rises -> FAULT with fault_cause=10 after 200 cycles in ACCEL; accelerated rising in cycle 200 -> CRUISE instead.
REQ-038 go held high across reset release -> stays in IDLE with no accel_start; go low then high -> run starts.
REQ-039 reset_n=0 in CRUISE -> all outputs 0 asynchronously, state=0.

Source files
------------

// File: rtl/drive_sequencer.sv
// drive_sequencer: go -> accel -> cruise -> decel -> done motor run sequencer.
// Optional SEQ_WATCHDOG_EN adds an ACCEL/DECEL phase watchdog (fault_cause=10).
module drive_sequencer #(
  parameter int CRUISE_US = 2000000,
  parameter int WDOG_US   = 1200000,
  parameter int CNT_W     = 22
) (
  input  logic       clk_1mhz,
  input  logic       reset_n,
  input  logic       go,
  input  logic       stop_req,
  input  logic       estop,
  input  logic       fault_clr,
  input  logic       accelerated,
  input  logic       accel_pwm,
  input  logic       decelerated,
  input  logic       decel_pwm,
  output logic       accel_start,
  output logic       decel_start,
  output logic       pwm_out,
  output logic       busy,
  output logic       done,
  output logic       fault,
  output logic [1:0] fault_cause,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ACCEL  = 3'd1,
    S_CRUISE = 3'd2,
    S_DECEL  = 3'd3,
    S_DONE   = 3'd4,
    S_FAULT  = 3'd5
  } state_e;

  localparam logic [CNT_W-1:0] CRUISE_LAST =
    CNT_W'(CRUISE_US - 1);
  localparam int MAX_US =
    (CRUISE_US > WDOG_US) ? CRUISE_US : WDOG_US;

  if ((64'd1 << CNT_W) <= 64'(MAX_US)) begin : g_cnt_w_chk
    $error("CNT_W too narrow for phase durations");
  end

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       cause_q, cause_d;
  logic             go_prev_q, acc_prev_q, dec_prev_q;
  logic             stop_lat_q, stop_lat_d;
  logic             pwm_q, pwm_d;
  logic             as_q, as_d;
  logic             ds_q, ds_d;
  logic             go_rise, acc_rise, dec_rise;

  assign go_rise  = go & ~go_prev_q;
  assign acc_rise = accelerated & ~acc_prev_q;
  assign dec_rise = decelerated & ~dec_prev_q;

`ifdef SEQ_WATCHDOG_EN
  localparam logic [CNT_W-1:0] WDOG_LAST =
    CNT_W'(WDOG_US - 1);
  logic wd_exp;
  assign wd_exp = (cnt_q == WDOG_LAST);
`endif

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      S_IDLE: begin
        if (go_rise) state_d = S_ACCEL;
      end
      S_ACCEL: begin
        if (acc_rise) begin
          state_d = (stop_lat_q | stop_req) ?
                    S_DECEL : S_CRUISE;
        end
`ifdef SEQ_WATCHDOG_EN
        else if (wd_exp) begin
          state_d = S_FAULT;
          cause_d = 2'b10;
        end
`endif
      end
      S_CRUISE: begin
        if (cnt_q == CRUISE_LAST || stop_req)
          state_d = S_DECEL;
      end
      S_DECEL: begin
        if (dec_rise) state_d = S_DONE;
`ifdef SEQ_WATCHDOG_EN
        else if (wd_exp) begin
          state_d = S_FAULT;
          cause_d = 2'b10;
        end
`endif
      end
      S_DONE: begin
        if (!go) state_d = S_IDLE;
      end
      S_FAULT: begin
        if (fault_clr && !estop) begin
          state_d = S_IDLE;
          cause_d = 2'b00;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // estop overrides every other transition
    if (estop && state_q != S_IDLE) begin
      state_d = S_FAULT;
      cause_d = 2'b01;
    end
  end

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q)
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    stop_lat_d = (state_q == S_ACCEL) &
                 (stop_lat_q | stop_req);
    as_d = (state_d == S_ACCEL) & (state_q != S_ACCEL);
    ds_d = (state_d == S_DECEL) & (state_q != S_DECEL);
    pwm_d = 1'b0;
    unique case (state_d)
      S_ACCEL:  pwm_d = accel_pwm;
      S_CRUISE: pwm_d = 1'b1;
      S_DECEL:  pwm_d = decel_pwm;
      default:  pwm_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk_1mhz or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cause_q    <= 2'b00;
      go_prev_q  <= 1'b1;
      acc_prev_q <= 1'b0;
      dec_prev_q <= 1'b0;
      stop_lat_q <= 1'b0;
      pwm_q      <= 1'b0;
      as_q       <= 1'b0;
      ds_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cause_q    <= cause_d;
      go_prev_q  <= go;
      acc_prev_q <= accelerated;
      dec_prev_q <= decelerated;
      stop_lat_q <= stop_lat_d;
      pwm_q      <= pwm_d;
      as_q       <= as_d;
      ds_q       <= ds_d;
    end
  end

  assign accel_start = as_q;
  assign decel_start = ds_q;
  assign pwm_out     = pwm_q;
  assign fault_cause = cause_q;
  assign state       = state_q;
  assign busy        = (state_q == S_ACCEL) ||
                       (state_q == S_CRUISE) ||
                       (state_q == S_DECEL);
  assign done        = (state_q == S_DONE);
  assign fault       = (state_q == S_FAULT);

endmodule

// File: tb/tb_drive_sequencer.sv
// Bench for drive_sequencer: cycle model plus directed run scenarios.
// Define SEQ_WATCHDOG_EN to also exercise the watchdog.
module tb_drive_sequencer;
  localparam int CR = 50;
  localparam int WD = 200;
`ifdef SEQ_WATCHDOG_EN
  localparam bit WD_ON = 1'b1;
`else
  localparam bit WD_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic go = 1'b0, stop_req = 1'b0, estop = 1'b0;
  logic fault_clr = 1'b0;
  logic accelerated = 1'b0, accel_pwm = 1'b0;
  logic decelerated = 1'b0, decel_pwm = 1'b0;
  logic accel_start, decel_start, pwm_out;
  logic busy, done, fault;
  logic [1:0] fault_cause;
  logic [2:0] state;

  int checks = 0, errors = 0;
  int n_as = 0, n_ds = 0;
  int cr_len = 0, ac_len = 0, cr_pwm_bad = 0;

  always #5 clk = ~clk;

  drive_sequencer #(
    .CRUISE_US(CR),
    .WDOG_US(WD),
    .CNT_W(22)
  ) dut (
    .clk_1mhz(clk),
    .reset_n(rst_n),
    .go(go),
    .stop_req(stop_req),
    .estop(estop),
    .fault_clr(fault_clr),
    .accelerated(accelerated),
    .accel_pwm(accel_pwm),
    .decelerated(decelerated),
    .decel_pwm(decel_pwm),
    .accel_start(accel_start),
    .decel_start(decel_start),
    .pwm_out(pwm_out),
    .busy(busy),
    .done(done),
    .fault(fault),
    .fault_cause(fault_cause),
    .state(state)
  );

  // Reference model: m_age counts cycles spent in the current state (1 = first).
  int m_st = 0, m_cause = 0, m_age = 1;
  int nst, ncause;
  bit m_pwm = 0, m_as = 0, m_ds = 0, m_stop = 0;
  bit pg = 1, pa = 0, pd = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_st = 0; m_cause = 0; m_age = 1;
      m_pwm = 0; m_as = 0; m_ds = 0; m_stop = 0;
      pg = 1; pa = 0; pd = 0;
    end else begin
      nst = m_st;
      ncause = m_cause;
      case (m_st)
        0: if (go && !pg) nst = 1;
        1: begin
          if (accelerated && !pa)
            nst = (m_stop || stop_req) ? 3 : 2;
          else if (WD_ON && m_age == WD) begin
            nst = 5; ncause = 2;
          end
        end
        2: if (m_age == CR || stop_req) nst = 3;
        3: begin
          if (decelerated && !pd) nst = 4;
          else if (WD_ON && m_age == WD) begin
            nst = 5; ncause = 2;
          end
        end
        4: if (!go) nst = 0;
        5: if (fault_clr && !estop) begin
          nst = 0; ncause = 0;
        end
        default: nst = 0;
      endcase
      if (m_st != 0 && estop) begin
        nst = 5; ncause = 1;
      end
      m_as = (nst == 1) && (m_st != 1);
      m_ds = (nst == 3) && (m_st != 3);
      m_pwm = (nst == 1) ? accel_pwm :
              (nst == 2) ? 1'b1 :
              (nst == 3) ? decel_pwm : 1'b0;
      m_stop = (m_st == 1) && (m_stop || stop_req);
      m_age = (nst != m_st) ? 1 : m_age + 1;
      m_st = nst;
      m_cause = ncause;
      pg = go; pa = accelerated; pd = decelerated;
    end
  end

  logic [10:0] act_v, exp_v;
  always_comb begin
    act_v = {state, fault_cause, accel_start, decel_start,
             pwm_out, busy, done, fault};
    exp_v = {3'(m_st), 2'(m_cause), m_as, m_ds, m_pwm,
             (m_st >= 1 && m_st <= 3), (m_st == 4),
             (m_st == 5)};
  end

  always @(posedge clk) begin
    #1;
    checks++;
    if (act_v !== exp_v) begin
      errors++;
      $display("FAIL model t=%0t: got %h expected %h",
               $time, act_v, exp_v);
    end
    if (accel_start) n_as++;
    if (decel_start) n_ds++;
    if (state == 3'd2) cr_len++;
    if (state == 3'd1) ac_len++;
    if (state == 3'd2 && !pwm_out) cr_pwm_bad++;
  end

  initial begin
    forever begin
      @(negedge clk);
      accel_pwm = 1'($urandom_range(0, 1));
      decel_pwm = 1'($urandom_range(0, 1));
    end
  end

  task automatic chk(input string nm, input int act,
                     input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic edge1();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_st(input int s, input int budget,
                         input string nm);
    int k;
    k = 0;
    while (int'(state) != s && k < budget) begin
      edge1();
      k++;
    end
    chk(nm, int'(state), s);
  endtask

  initial begin
    cyc(3);
    chk("reset_outputs", int'(act_v), 0);
    rst_n = 1'b1;
    cyc(3);
    chk("idle_after_reset", int'(state), 0);

    // Full run
    n_as = 0; n_ds = 0; cr_len = 0;
    go = 1'b1;
    edge1();
    chk("accel_entry", int'(state), 1);
    chk("accel_start_pulse", int'(accel_start), 1);
    cyc(100);
    accelerated = 1'b1;
    edge1();
    chk("cruise_entry", int'(state), 2);
    chk("cruise_pwm", int'(pwm_out), 1);
    wait_st(3, 60, "decel_after_cruise");
    chk("cruise_len", cr_len, 50);
    chk("decel_start_pulse", int'(decel_start), 1);
    cyc(100);
    decelerated = 1'b1;
    wait_st(4, 3, "done_entry");
    chk("done_flag", int'(done), 1);
    cyc(3);
    chk("done_holds_while_go", int'(state), 4);
    go = 1'b0;
    edge1();
    chk("idle_after_done", int'(state), 0);
    chk("run1_accel_starts", n_as, 1);
    chk("run1_decel_starts", n_ds, 1);
    chk("cruise_pwm_high", cr_pwm_bad, 0);

    // Early stop in cruise; completion inputs high from last run
    n_ds = 0; cr_len = 0;
    cyc(1);
    go = 1'b1;
    edge1();
    chk("run2_accel", int'(state), 1);
    cyc(1);
    accelerated = 1'b0;
    cyc(20);
    chk("accel_level_ignored", int'(state), 1);
    accelerated = 1'b1;
    wait_st(2, 3, "run2_cruise");
    cyc(10);
    stop_req = 1'b1;
    edge1();
    chk("stop_to_decel", int'(state), 3);
    chk("stop_decel_start", int'(decel_start), 1);
    chk("cruise_cut_len", cr_len, 10);
    cyc(1);
    stop_req = 1'b0;
    decelerated = 1'b0;
    cyc(20);
    chk("decel_level_ignored", int'(state), 3);
    decelerated = 1'b1;
    wait_st(4, 3, "run2_done");
    go = 1'b0;
    wait_st(0, 3, "run2_idle");
    chk("run2_decel_starts", n_ds, 1);

    // Stop latched during accel, then estop in decel
    cyc(1);
    go = 1'b1;
    edge1();
    cyc(1);
    accelerated = 1'b0;
    stop_req = 1'b1;
    cyc(1);
    stop_req = 1'b0;
    cyc(5);
    accelerated = 1'b1;
    edge1();
    chk("latched_stop_decel", int'(state), 3);
    cyc(3);
    estop = 1'b1;
    edge1();
    chk("estop_fault", int'(state), 5);
    chk("estop_cause", int'(fault_cause), 1);
    chk("estop_pwm", int'(pwm_out), 0);
    chk("estop_fault_flag", int'(fault), 1);
    cyc(1);
    go = 1'b0;
    fault_clr = 1'b1;
    cyc(4);
    chk("fault_hold_estop", int'(state), 5);
    estop = 1'b0;
    edge1();
    chk("fault_clear_idle", int'(state), 0);
    chk("fault_cause_clear", int'(fault_cause), 0);
    cyc(1);
    fault_clr = 1'b0;

    // go held high through reset release
    go = 1'b1;
    rst_n = 1'b0;
    cyc(2);
    n_as = 0;
    rst_n = 1'b1;
    cyc(5);
    chk("go_high_reset_idle", int'(state), 0);
    chk("go_high_no_start", n_as, 0);
    go = 1'b0;
    cyc(2);
    go = 1'b1;
    edge1();
    chk("go_retoggle_start", int'(state), 1);

    // Async reset mid-cruise
    cyc(1);
    accelerated = 1'b0;
    cyc(2);
    accelerated = 1'b1;
    wait_st(2, 3, "pre_reset_cruise");
    cyc(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset_out", int'(act_v), 0);
    cyc(2);
    n_as = 0;
    go = 1'b0;
    accelerated = 1'b0;
    rst_n = 1'b1;
    cyc(4);
    chk("post_reset_no_start", n_as, 0);

`ifdef SEQ_WATCHDOG_EN
    ac_len = 0;
    go = 1'b1;
    edge1();
    wait_st(5, 210, "wdog_fault");
    chk("wdog_accel_len", ac_len, 200);
    chk("wdog_cause", int'(fault_cause), 2);
    cyc(1);
    go = 1'b0;
    fault_clr = 1'b1;
    edge1();
    chk("wdog_clear", int'(state), 0);
    cyc(1);
    fault_clr = 1'b0;
    go = 1'b1;
    edge1();
    chk("wdog2_accel", int'(state), 1);
    cyc(200);
    accelerated = 1'b1;
    edge1();
    chk("wdog_edge_precedence", int'(state), 2);
`else
    go = 1'b1;
    edge1();
    cyc(250);
    chk("no_watchdog_accel", int'(state), 1);
    estop = 1'b1;
    edge1();
    chk("no_wdog_estop_cause", int'(fault_cause), 1);
`endif
    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
